// File: rtl/g15_io_pkg.sv
// Shared types for the G-15 connector PL1 peripherals: function-key
// indices, coupler FSM states and a helper that sanitises millisecond counts.
package g15_io_pkg;

    localparam int FKEY_N = 11;

    typedef enum logic [3:0] {
        CIR_S = 4'd0,
        A     = 4'd1,
        B     = 4'd2,
        C     = 4'd3,
        F_B   = 4'd4,
        I     = 4'd5,
        M     = 4'd6,
        P     = 4'd7,
        Q     = 4'd8,
        R     = 4'd9,
        T     = 4'd10
    } fkey_e;

    typedef enum logic [1:0] {
        IDLE,
        KEY_HOLD,
        KEY_GAP,
        STRIKE
    } coupler_state_t;

    // A zero duration would never expire, so it is treated as one tick.
    function automatic logic [7:0] clamp_ms(input int unsigned ms);
        return (ms == 0) ? 8'd1 : ms[7:0];
    endfunction

endpackage

// File: rtl/typewriter_coupler_ms_timer.sv
// Shared millisecond down-counter: load a duration, count tick_ms pulses,
// flag the tick that brings the count to zero.
module ms_timer (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] value,
    output logic       done
);

    logic [7:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= value;
        end else if (tick && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    // Asserted during the cycle of the final counted tick, so the owner can
    // drop its lines on that edge and have them low in the following cycle.
    assign done = tick && (count <= 8'd1);

endmodule

// File: rtl/typewriter_coupler.sv
// ANC-2 style typewriter coupler: buffers printed codes from PL1, echoes them
// on LEV*_OUT, and converts host keystrokes into timed key-line closures.
module typewriter_coupler
    import g15_io_pkg::*;
#(
    parameter int unsigned KEY_MS    = 50,
    parameter int unsigned GAP_MS    = 20,
    parameter int unsigned STRIKE_MS = 40
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              tick_ms,
    input  logic              type_i,
    input  logic              exc_i,
    input  logic [4:0]        lev_in,
    input  logic              kb_valid,
    input  logic              kb_func,
    input  logic [4:0]        kb_code,
    output logic              kb_ready,
    output logic              pr_valid,
    output logic [4:0]        pr_code,
    input  logic              pr_ready,
    input  logic              ovr_clr,
    output logic              ovr,
    output logic [4:0]        lev_out,
    output logic [FKEY_N-1:0] fkey
);

    localparam logic [7:0]        KEY_T     = clamp_ms(KEY_MS);
    localparam logic [7:0]        GAP_T     = clamp_ms(GAP_MS);
    localparam logic [7:0]        STRIKE_T  = clamp_ms(STRIKE_MS);
    localparam logic [4:0]        FKEY_LAST = 5'(FKEY_N - 1);
    localparam logic [FKEY_N-1:0] FKEY_ONE  = {{(FKEY_N-1){1'b0}}, 1'b1};

    coupler_state_t    state, state_nxt;
    logic [4:0]        lev_nxt;
    logic [FKEY_N-1:0] fkey_nxt;
    logic              exc_q, type_q;
    logic              exc_rise, type_rise, capture, can_take, accept;
    logic              tmr_load, tmr_done;
    logic [7:0]        tmr_value;

    assign exc_rise  = exc_i & ~exc_q;
    assign type_rise = type_i & ~type_q;
    assign capture   = exc_rise & type_i;
    assign can_take  = ~pr_valid | pr_ready;
    assign accept    = rst & kb_valid & ~type_i;

    ms_timer u_timer (
        .CLOCK (CLOCK),
        .rst   (rst),
        .tick  (tick_ms),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    // Print buffer: one entry; a capture into a full, unconsumed buffer is an overrun.
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            exc_q    <= 1'b0;
            type_q   <= 1'b0;
            pr_valid <= 1'b0;
            pr_code  <= 5'd0;
            ovr      <= 1'b0;
        end else begin
            exc_q  <= exc_i;
            type_q <= type_i;
            if (capture && can_take) begin
                pr_code  <= lev_in;
                pr_valid <= 1'b1;
            end else if (!capture && pr_valid && pr_ready) begin
                pr_valid <= 1'b0;
            end
            if (capture && !can_take) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state   <= IDLE;
            lev_out <= 5'd0;
            fkey    <= '0;
        end else begin
            state   <= state_nxt;
            lev_out <= lev_nxt;
            fkey    <= fkey_nxt;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nxt = state;
        lev_nxt   = lev_out;
        fkey_nxt  = fkey;
        tmr_load  = 1'b0;
        tmr_value = KEY_T;
        kb_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = STRIKE;
                    lev_nxt   = lev_in;
                    tmr_load  = 1'b1;
                    tmr_value = STRIKE_T;
                end else if (accept) begin
                    kb_ready  = 1'b1;
                    state_nxt = KEY_HOLD;
                    tmr_load  = 1'b1;
                    tmr_value = KEY_T;
                    if (!kb_func) begin
                        lev_nxt = kb_code;
                    end else if (kb_code <= FKEY_LAST) begin
                        fkey_nxt = FKEY_ONE << kb_code;
                    end
                end
            end
            KEY_HOLD: begin
                if (type_rise) begin
                    state_nxt = IDLE;
                    lev_nxt   = 5'd0;
                    fkey_nxt  = '0;
                end else if (tmr_done) begin
                    state_nxt = KEY_GAP;
                    lev_nxt   = 5'd0;
                    fkey_nxt  = '0;
                    tmr_load  = 1'b1;
                    tmr_value = GAP_T;
                end
            end
            KEY_GAP: begin
                if (type_rise || tmr_done) begin
                    state_nxt = IDLE;
                end
            end
            STRIKE: begin
                // A new type pulse restarts the echo with the fresh code.
                if (capture) begin
                    lev_nxt   = lev_in;
                    tmr_load  = 1'b1;
                    tmr_value = STRIKE_T;
                end else if (tmr_done) begin
                    state_nxt = IDLE;
                    lev_nxt   = 5'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                lev_nxt   = 5'd0;
                fkey_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_typewriter_coupler.sv
// Directed bench for typewriter_coupler with short key, gap and strike times
// so each timing edge can be stepped tick by tick.
module tb_typewriter_coupler;

    logic        CLOCK = 1'b0;
    logic        rst;
    logic        tick_ms, type_i, exc_i, kb_valid, kb_func, pr_ready, ovr_clr;
    logic [4:0]  lev_in, kb_code;
    logic        kb_ready, pr_valid, ovr;
    logic [4:0]  pr_code, lev_out;
    logic [10:0] fkey;

    int errors = 0;
    int checks = 0;

    typewriter_coupler #(
        .KEY_MS    (3),
        .GAP_MS    (2),
        .STRIKE_MS (4)
    ) dut (
        .CLOCK    (CLOCK),
        .rst      (rst),
        .tick_ms  (tick_ms),
        .type_i   (type_i),
        .exc_i    (exc_i),
        .lev_in   (lev_in),
        .kb_valid (kb_valid),
        .kb_func  (kb_func),
        .kb_code  (kb_code),
        .kb_ready (kb_ready),
        .pr_valid (pr_valid),
        .pr_code  (pr_code),
        .pr_ready (pr_ready),
        .ovr_clr  (ovr_clr),
        .ovr      (ovr),
        .lev_out  (lev_out),
        .fkey     (fkey)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock with an optional millisecond tick; returns 1 time unit after the edge.
    task automatic clk1(input logic t);
        tick_ms = t;
        @(posedge CLOCK);
        #1;
        tick_ms = 1'b0;
    endtask

    initial begin
        rst = 1'b0; tick_ms = 1'b0; type_i = 1'b0; exc_i = 1'b0; lev_in = 5'd0;
        kb_valid = 1'b1; kb_func = 1'b0; kb_code = 5'd0; pr_ready = 1'b0; ovr_clr = 1'b0;

        // Reset
        clk1(1'b0);
        clk1(1'b0);
        check("rst_lev_out", 16'(lev_out), 16'h0);
        check("rst_fkey", 16'(fkey), 16'h0);
        check("rst_pr_valid", 16'(pr_valid), 16'h0);
        check("rst_pr_code", 16'(pr_code), 16'h0);
        check("rst_ovr", 16'(ovr), 16'h0);
        check("rst_kb_ready", 16'(kb_ready), 16'h0);
        kb_valid = 1'b0;
        rst = 1'b1;
        clk1(1'b0);

        // Data key 0x13, tick in the accept cycle must not count
        kb_valid = 1'b1; kb_func = 1'b0; kb_code = 5'h13;
        #1 check("key_accept", 16'(kb_ready), 16'h1);
        clk1(1'b1);
        kb_valid = 1'b0;
        #1 check("key_ready_drop", 16'(kb_ready), 16'h0);
        check("key_lev_on", 16'(lev_out), 16'h13);
        clk1(1'b1);
        clk1(1'b0);
        clk1(1'b1);
        check("key_lev_after_2", 16'(lev_out), 16'h13);
        check("key_fkey_zero", 16'(fkey), 16'h0);
        clk1(1'b1);
        check("key_lev_after_3", 16'(lev_out), 16'h0);
        kb_valid = 1'b1;
        #1 check("gap_ready_0", 16'(kb_ready), 16'h0);
        clk1(1'b1);
        check("gap_ready_1", 16'(kb_ready), 16'h0);
        clk1(1'b1);
        check("gap_done_ready", 16'(kb_ready), 16'h1);

        // Function key A (index 1)
        kb_func = 1'b1; kb_code = 5'd1;
        clk1(1'b0);
        kb_valid = 1'b0;
        #1 check("fk_on", 16'(fkey), 16'h002);
        check("fk_lev_zero", 16'(lev_out), 16'h0);
        clk1(1'b1);
        clk1(1'b1);
        check("fk_hold_2", 16'(fkey), 16'h002);
        clk1(1'b1);
        check("fk_off", 16'(fkey), 16'h0);
        clk1(1'b1);
        clk1(1'b1);

        // Out-of-range function key: accepted but drives nothing
        kb_valid = 1'b1; kb_func = 1'b1; kb_code = 5'd12;
        #1 check("fk12_accept", 16'(kb_ready), 16'h1);
        clk1(1'b0);
        #1 check("fk12_busy", 16'(kb_ready), 16'h0);
        kb_valid = 1'b0;
        check("fk12_fkey", 16'(fkey), 16'h0);
        check("fk12_lev", 16'(lev_out), 16'h0);
        repeat (5) clk1(1'b1);

        // Print path
        type_i = 1'b1; lev_in = 5'h0A; exc_i = 1'b1;
        clk1(1'b0);
        exc_i = 1'b0;
        check("pr_valid", 16'(pr_valid), 16'h1);
        check("pr_code", 16'(pr_code), 16'h0A);
        check("strike_lev", 16'(lev_out), 16'h0A);
        kb_valid = 1'b1;
        #1 check("type_blocks_kb", 16'(kb_ready), 16'h0);
        kb_valid = 1'b0;
        repeat (3) clk1(1'b1);
        check("strike_lev_3", 16'(lev_out), 16'h0A);
        clk1(1'b1);
        check("strike_end", 16'(lev_out), 16'h0);
        lev_in = 5'h07; exc_i = 1'b1;
        clk1(1'b0);
        exc_i = 1'b0;
        check("ovr_set", 16'(ovr), 16'h1);
        check("ovr_code_kept", 16'(pr_code), 16'h0A);
        check("ovr_strike_lev", 16'(lev_out), 16'h07);
        ovr_clr = 1'b1;
        clk1(1'b0);
        ovr_clr = 1'b0;
        check("ovr_clr", 16'(ovr), 16'h0);

        // Simultaneous consume and capture
        lev_in = 5'h1F; exc_i = 1'b1; pr_ready = 1'b1;
        clk1(1'b0);
        exc_i = 1'b0; pr_ready = 1'b0;
        check("simul_valid", 16'(pr_valid), 16'h1);
        check("simul_code", 16'(pr_code), 16'h1F);
        check("simul_ovr", 16'(ovr), 16'h0);
        check("restart_lev", 16'(lev_out), 16'h1F);
        clk1(1'b0);
        lev_in = 5'h03; exc_i = 1'b1; ovr_clr = 1'b1;
        clk1(1'b0);
        exc_i = 1'b0; ovr_clr = 1'b0;
        check("ovr_set_wins", 16'(ovr), 16'h1);
        check("ovr2_code_kept", 16'(pr_code), 16'h1F);
        pr_ready = 1'b1;
        clk1(1'b0);
        pr_ready = 1'b0;
        check("pr_drain", 16'(pr_valid), 16'h0);
        ovr_clr = 1'b1;
        clk1(1'b0);
        ovr_clr = 1'b0;
        repeat (4) clk1(1'b1);
        check("strike2_end", 16'(lev_out), 16'h0);
        type_i = 1'b0; lev_in = 5'h1C; exc_i = 1'b1;
        clk1(1'b0);
        exc_i = 1'b0;
        clk1(1'b0);
        check("exc_no_type_buf", 16'(pr_valid), 16'h0);
        check("exc_no_type_lev", 16'(lev_out), 16'h0);

        // Abort mid-hold when the computer starts typing
        kb_valid = 1'b1; kb_func = 1'b0; kb_code = 5'h15;
        #1 check("abort_accept", 16'(kb_ready), 16'h1);
        clk1(1'b0);
        kb_valid = 1'b0;
        check("abort_lev_on", 16'(lev_out), 16'h15);
        clk1(1'b1);
        type_i = 1'b1;
        clk1(1'b0);
        check("abort_lev", 16'(lev_out), 16'h0);
        check("abort_fkey", 16'(fkey), 16'h0);
        kb_valid = 1'b1;
        #1 check("abort_type_ready", 16'(kb_ready), 16'h0);
        type_i = 1'b0;
        #1 check("abort_idle_ready", 16'(kb_ready), 16'h1);
        kb_valid = 1'b0;
        clk1(1'b0);

        // Reset mid-strike
        type_i = 1'b1; lev_in = 5'h11; exc_i = 1'b1;
        clk1(1'b0);
        exc_i = 1'b0;
        check("rs_lev_on", 16'(lev_out), 16'h11);
        rst = 1'b0;
        clk1(1'b0);
        type_i = 1'b0; kb_valid = 1'b1;
        #1 check("rs_lev", 16'(lev_out), 16'h0);
        check("rs_pr_valid", 16'(pr_valid), 16'h0);
        check("rs_pr_code", 16'(pr_code), 16'h0);
        check("rs_kb_ready", 16'(kb_ready), 16'h0);
        kb_valid = 1'b0;
        rst = 1'b1;
        clk1(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
